// File: rtl/nios_pio_pkg.sv
// Purpose: shared register map and edge-type encodings for the Nios II Avalon-MM PIO family.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
//
// Contents:
//   pio_addr_t        2-bit Avalon word address
//   PIO_ADDR_*        register word addresses common to all PIOs on the segment
//   EDGE_*            encodings for the EDGE_TYPE parameter of input PIOs
//   PIO_DATA_W        Avalon data width
package nios_pio_pkg;

  typedef logic [1:0] pio_addr_t;

  localparam pio_addr_t PIO_ADDR_DATA    = 2'd0;
  // Direction register slot; input-only PIOs leave it reserved and read 0.
  localparam pio_addr_t PIO_ADDR_DIR     = 2'd1;
  localparam pio_addr_t PIO_ADDR_IRQMASK = 2'd2;
  localparam pio_addr_t PIO_ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  localparam int unsigned PIO_DATA_W = 32;

endpackage

// File: rtl/nios_pio_debounce.sv
// Purpose: one-bit 2-flop synchronizer plus stability-counter debouncer for a raw button line.
// Latency: input change to level_o change = 2 + DEBOUNCE_CYCLES clk cycles.
// Backpressure: none; free-running, samples every cycle.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   in_i         raw asynchronous input line
//   level_o      debounced level
//   level_dly_o  debounced level delayed one cycle (for edge detection)
module nios_pio_debounce
  import nios_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic level_o,
  output logic level_dly_o
);

  // Sized to hold DEBOUNCE_CYCLES, although the count never exceeds DEBOUNCE_CYCLES-1.
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_dly_q;

  // Any cycle where the synchronized input agrees with the accepted level
  // restarts the count, so only an unbroken run of DEBOUNCE_CYCLES differing
  // samples moves the level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Sync stages and the delayed level reset to the same value as the level,
  // so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= RESET_VAL;
      sync2_q     <= RESET_VAL;
      cnt_q       <= '0;
      level_q     <= RESET_VAL;
      level_dly_q <= RESET_VAL;
    end else begin
      sync1_q     <= in_i;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  assign level_o     = level_q;
  assign level_dly_o = level_dly_q;

endmodule

// File: rtl/nios_button_pio.sv
// Purpose: Avalon-MM input PIO; debounced button lines, W1C edge capture, masked level irq.
// Latency: pin to data 2+DEBOUNCE_CYCLES cycles; edgecapture +1; irq +1; readdata 1 cycle.
// Backpressure: none; writes take effect with zero wait states, reads need one fixed wait state.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   address           Avalon word address (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect        Avalon select
//   write_n           active-low write strobe
//   writedata         write data; bits above WIDTH ignored
//   in_port           raw external button/switch lines
//   readdata          registered read data; bits above WIDTH read 0
//   irq               active-high level interrupt = any unmasked pending edge
module nios_button_pio
  import nios_pio_pkg::*;
#(
  parameter int unsigned     WIDTH           = 4,
  parameter int unsigned     DEBOUNCE_CYCLES = 50000,
  parameter int unsigned     EDGE_TYPE       = EDGE_FALL,
  parameter logic [WIDTH-1:0] RESET_LEVEL    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_dly;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;

  logic             wr_en;
  logic [WIDTH-1:0] clr;

  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic             irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;

  // Upper write-data bits have no register behind them.
  logic             unused_wdata;
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_line
    nios_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (RESET_LEVEL[i])
    ) u_debounce (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_i        (in_port[i]),
      .level_o     (level[i]),
      .level_dly_o (level_dly[i])
    );
  end

  assign rise = level & ~level_dly;
  assign fall = ~level & level_dly;

  always_comb begin
    edge_det = rise | fall;
    if (EDGE_TYPE == EDGE_RISE) begin
      edge_det = rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      edge_det = fall;
    end
  end

  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && (address == PIO_ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_en && (address == PIO_ADDR_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
  end

  // Edge is OR'd in after the clear so an edge landing in the same cycle as
  // its W1C write is not lost.
  assign edgecap_d = (edgecap_q & ~clr) | edge_det;

  // irq follows the registered state, so it lags edgecapture/irqmask by one cycle.
  assign irq_d = |(edgecap_q & irqmask_q);

  // Read mux ignores chipselect/write_n: the master always spends one wait
  // state and picks up whatever the previous cycle's address selected.
  always_comb begin
    readdata_d = '0;
    case (address)
      PIO_ADDR_DATA:    readdata_d[WIDTH-1:0] = level;
      PIO_ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      PIO_ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:          readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: doc/nios_button_pio.md
Name: nios_button_pio

Overview:
- Avalon-MM input PIO, the read-side counterpart to the design's write-only output PIOs.
- Samples WIDTH external push-button/switch lines, synchronizes and debounces them, and captures edges into a write-1-to-clear register.
- Raises a level interrupt to the Nios II when an unmasked edge is pending.
- Sits on the same Avalon bus segment as the existing LCD and config PIOs.

Parameters:
- WIDTH, 4, number of input lines (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required before a new level is accepted (>=1).
- EDGE_TYPE, 1, edges to capture: 0 = rising, 1 = falling, 2 = any.
- RESET_LEVEL, all ones (WIDTH bits), reset value of the debounced level; buttons are active-low.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  Avalon word address.
- chipselect  input  1  Avalon select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  raw asynchronous external lines.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt, active-high.

Behaviour:
- Reset:
  - Sync stages and debounced level = RESET_LEVEL.
  - Debounce counters, edgecapture, irqmask, readdata = 0; irq = 0.
- Synchronizer: 2 flops per bit (sync1 -> sync2); sync2 is the only consumer of in_port.
- Debounce, per bit independent:
  - If sync2 == level, counter clears to 0.
  - Otherwise counter increments; when it reaches DEBOUNCE_CYCLES-1 while still differing, level <= sync2 and counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes level.
  - Counter width is clog2(DEBOUNCE_CYCLES+1); it never wraps.
- Latency: in_port change -> level change = 2 + DEBOUNCE_CYCLES clk cycles.
- Edge detect: level_d is level delayed one cycle.
  - rise = level & ~level_d; fall = ~level & level_d.
  - edge is selected by EDGE_TYPE.
- Register map (32-bit words; bits above WIDTH read 0, writes ignored):
  - addr 0: data, RO = debounced level; writes ignored.
  - addr 1: reserved, reads 0.
  - addr 2: irqmask, RW, bits [WIDTH-1:0].
  - addr 3: edgecapture, R/W1C. A write with chipselect & ~write_n clears bits where writedata = 1.
- Edgecapture update per bit: next = (cur & ~clr) | edge. A new edge in the same cycle as a clear of that bit wins (bit stays 1).
- Writes take effect at the clock edge where chipselect & ~write_n; zero wait states.
- readdata:
  - Registered every cycle from the current address mux, independent of chipselect and write_n.
  - Master uses 1 read wait state; readdata reflects register state one cycle before.
- irq = |(edgecapture & irqmask), registered. irq asserts 1 cycle after the edgecapture bit sets and deasserts 1 cycle after the clear or mask write.
- Reset mid-debounce discards the counter and returns level to RESET_LEVEL. An edge is captured only if level later differs from RESET_LEVEL.
- Reset forces no spurious edge: level_d resets to RESET_LEVEL too.

Decomposition:
- Shared package nios_pio_pkg:
  - Address constants PIO_ADDR_DATA = 0, PIO_ADDR_DIR = 1, PIO_ADDR_IRQMASK = 2, PIO_ADDR_EDGECAP = 3.
  - EDGE_RISE, EDGE_FALL, EDGE_ANY encodings.
- Sub-module nios_pio_debounce: single bit, 2-flop sync + counter + level + level_d, with parameters DEBOUNCE_CYCLES and RESET_VAL. Generated WIDTH times.
- The top holds the register file, edge logic, read mux and irq.

Test Plan:
1. Reset, then read addr 0 -> readdata = 0x0000000F (WIDTH=4, RESET_LEVEL=4'hF); irq = 0; addr 2 and addr 3 read 0.
2. DEBOUNCE_CYCLES=8: drive in_port[0] = 0 for 5 cycles, then back to 1 -> data stays 0xF; edgecapture stays 0.
3. Hold in_port[0] = 0 -> data = 0xE exactly 10 cycles after the change. edgecapture = 0x1 one cycle later. irq stays 0 (mask = 0).
4. Write irqmask = 0x1 -> irq = 1 one cycle later. Write 0x1 to addr 3 -> edgecapture = 0 and irq = 0 one cycle after.
5. Arrange a debounced falling edge on bit 1 in the same cycle as a W1C write of 0x2 to addr 3 -> edgecapture bit 1 remains 1.
6. EDGE_TYPE=2: press and release bit 2, clearing edgecapture between the two -> edgecapture sets 0x4 on both edges. Assert reset_n = 0 mid-debounce -> all registers return to reset values immediately, with no edge captured after release of reset.
